// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates a one-hot column drive, debounces the first row hit,
// then tracks that single key through hold and a debounced release.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] COUNT_LAST = 16'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  rows_meta;
    logic [3:0]  rows_s;
    logic [15:0] dwell;
    logic [15:0] count;
    logic [1:0]  row_idx;
    logic [1:0]  col_idx;
    logic [1:0]  hit_row;
    logic [1:0]  drive_col;
    logic        row_on;
    logic        dwell_done;
    logic        count_done;
    logic        rotate;
    logic        capture;
    logic        accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_meta <= 4'b0000;
            rows_s    <= 4'b0000;
        end else begin
            rows_meta <= rows;
            rows_s    <= rows_meta;
        end
    end

    // Highest row wins when several rows are seen on one column.
    always_comb begin
        hit_row = 2'd0;
        if (rows_s[3])      hit_row = 2'd3;
        else if (rows_s[2]) hit_row = 2'd2;
        else if (rows_s[1]) hit_row = 2'd1;

        case (cols)
            4'b0010: drive_col = 2'd1;
            4'b0100: drive_col = 2'd2;
            4'b1000: drive_col = 2'd3;
            default: drive_col = 2'd0;
        endcase
    end

    assign row_on     = rows_s[row_idx];
    assign dwell_done = (dwell == DWELL_LAST);
    assign count_done = (count == COUNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SCAN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        rotate     = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            SCAN: begin
                if (dwell_done) begin
                    if (rows_s != 4'b0000) begin
                        state_next = DEBOUNCE;
                        capture    = 1'b1;
                    end else begin
                        rotate = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!row_on) begin
                    state_next = SCAN;
                    rotate     = 1'b1;
                end else if (count_done) begin
                    state_next = HELD;
                    accept     = 1'b1;
                end
            end
            HELD: begin
                if (!row_on) state_next = RELEASE;
            end
            RELEASE: begin
                if (!row_on && count_done) begin
                    state_next = SCAN;
                    rotate     = 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        key_held = (state == HELD) || (state == RELEASE);
    end

    // Counters are cleared on every state exit, so each state always starts from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cols      <= 4'b0001;
            key       <= 4'b0000;
            key_valid <= 1'b0;
            dwell     <= 16'd0;
            count     <= 16'd0;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
        end else begin
            key_valid <= accept;
            if (accept)  key <= {row_idx, col_idx};
            if (capture) begin
                row_idx <= hit_row;
                col_idx <= drive_col;
            end
            if (rotate)  cols <= {cols[2:0], cols[3]};

            if (state == SCAN && !dwell_done) dwell <= dwell + 16'd1;
            else                              dwell <= 16'd0;

            case (state)
                DEBOUNCE: begin
                    if (!row_on || count_done) count <= 16'd0;
                    else                       count <= count + 16'd1;
                end
                RELEASE: begin
                    if (row_on || count_done) count <= 16'd0;
                    else                      count <= count + 16'd1;
                end
                default: count <= 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives rows from cols,
// accepted keys are checked against a queue of expected codes.
module tb_keypad_scan_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;
    logic [3:0]  expected_q[$];
    int          vectors;
    int          miscompares;
    int          kv_count;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key (r,c) is bit r*4+c of pressed; it shorts row r to column c.
    always_comb begin
        rows = 4'b0000;
        for (int c = 0; c < 4; c++)
            if (cols[c])
                for (int r = 0; r < 4; r++)
                    if (pressed[r*4+c]) rows[r] = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input logic expect_key, input logic [3:0] exp_key);
        pressed = mask;
        if (expect_key) expected_q.push_back(exp_key);
    endtask

    task automatic waitForColumn(input logic [3:0] target);
        int n;
        n = 0;
        @(negedge clk);
        while (cols !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (cols !== target) checkOutput("wait_cols", 16'(cols), 16'(target));
    endtask

    always @(negedge clk) begin
        if (!reset && key_valid === 1'b1) begin
            kv_count++;
            if (expected_q.size() == 0) checkOutput("unexpected_key_valid", 16'(key_valid), 16'd0);
            else                        checkOutput("scoreboard_key", 16'(key), 16'(expected_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        logic [3:0] exp_cols;
        vectors     = 0;
        miscompares = 0;
        kv_count    = 0;
        reset       = 1'b1;
        pressed     = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("reset_cols", 16'(cols), 16'h0001);
        checkOutput("reset_key", 16'(key), 16'h0000);
        checkOutput("reset_key_valid", 16'(key_valid), 16'h0000);
        checkOutput("reset_key_held", 16'(key_held), 16'h0000);
        reset = 1'b0;

        // Idle scan: column index advances every 4 edges after reset release.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_cols = 4'(1 << ((k / 4) % 4));
            checkOutput("idle_cols", 16'(cols), 16'(exp_cols));
        end
        checkOutput("idle_no_key_valid", 16'(kv_count), 16'd0);

        // Clean press of (row 2, col 1) starting as column 1 is first driven.
        waitForColumn(4'b0001);
        waitForColumn(4'b0010);
        applyStimulus(16'h0200, 1'b1, 4'b1001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_valid !== 1'b1 && n < 40);
        checkOutput("press_latency", 16'(n), 16'd12);
        checkOutput("press_key", 16'(key), 16'h0009);
        checkOutput("press_key_held", 16'(key_held), 16'h0001);
        checkOutput("press_cols", 16'(cols), 16'h0002);
        @(negedge clk);
        checkOutput("kv_pulse_width", 16'(key_valid), 16'h0000);
        repeat (20) @(negedge clk);
        checkOutput("held_cols", 16'(cols), 16'h0002);
        checkOutput("held_key_held", 16'(key_held), 16'h0001);
        checkOutput("held_kv_count", 16'(kv_count), 16'd1);

        // Release with a one-cycle re-contact that restarts the release count.
        applyStimulus(16'h0000, 1'b0, 4'b0000);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 6) applyStimulus(16'h0200, 1'b0, 4'b0000);
            if (k == 7) applyStimulus(16'h0000, 1'b0, 4'b0000);
            if (k == 16) checkOutput("release_still_held", 16'(key_held), 16'h0001);
            if (k == 17) begin
                checkOutput("release_done_held", 16'(key_held), 16'h0000);
                checkOutput("release_next_col", 16'(cols), 16'h0004);
            end
        end
        checkOutput("release_key_kept", 16'(key), 16'h0009);

        // Short contact aborts debounce and scanning resumes at the next column.
        waitForColumn(4'b0010);
        applyStimulus(16'h0200, 1'b0, 4'b0000);
        repeat (6) @(negedge clk);
        checkOutput("bounce_frozen", 16'(cols), 16'h0002);
        applyStimulus(16'h0000, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("bounce_still_debounce", 16'(cols), 16'h0002);
        @(negedge clk);
        checkOutput("bounce_abort_col", 16'(cols), 16'h0004);
        repeat (12) @(negedge clk);
        checkOutput("bounce_kv_count", 16'(kv_count), 16'd1);
        checkOutput("bounce_key_kept", 16'(key), 16'h0009);
        checkOutput("bounce_not_held", 16'(key_held), 16'h0000);

        // Two rows on column 0: the higher row is reported, later keys are ignored.
        applyStimulus(16'h1010, 1'b1, 4'b1100);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_valid !== 1'b1 && n < 40);
        checkOutput("multi_found", 16'(key_valid), 16'h0001);
        checkOutput("multi_key", 16'(key), 16'h000c);
        checkOutput("multi_cols", 16'(cols), 16'h0001);
        applyStimulus(16'h1011, 1'b0, 4'b0000);
        repeat (30) @(negedge clk);
        checkOutput("multi_kv_count", 16'(kv_count), 16'd2);
        checkOutput("multi_key_held", 16'(key_held), 16'h0001);
        checkOutput("multi_key_kept", 16'(key), 16'h000c);

        // Reset mid-HELD, away from any clock edge.
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_held_cols", 16'(cols), 16'h0001);
        checkOutput("rst_held_key", 16'(key), 16'h0000);
        checkOutput("rst_held_key_held", 16'(key_held), 16'h0000);
        checkOutput("rst_held_key_valid", 16'(key_valid), 16'h0000);
        applyStimulus(16'h0000, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_cols", 16'(cols), 16'h0002);
        checkOutput("post_rst_key", 16'(key), 16'h0000);
        checkOutput("scoreboard_empty", 16'(expected_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
